// File: rtl/frame_write_burst_ctrl.sv
// frame_write_burst_ctrl
//   Write burst scheduler for one channel of the DDR write arbiter. Splits each
//   frame held in a show-ahead FIFO into bursts of at most BURST_LEN words,
//   rotates through BUF_NUM frame buffers, and never selects the buffer that
//   the read side currently owns.
// Ports
//   i_mem_clk, i_rst          clock, synchronous active-high reset
//   i_frame_start             1-cycle pulse: a new frame starts entering the FIFO
//   i_rd_buf_idx              buffer currently owned by the read side
//   i_fifo_rd_count/_data     FIFO fill level and head word
//   o_fifo_rd_en              FIFO pop (combinational)
//   o_wr_burst_req/len/addr   burst request to the arbiter channel
//   i_wr_burst_data_req       arbiter takes one word this cycle
//   o_wr_burst_data           write data (combinational)
//   i_wr_burst_finish         1-cycle pulse: burst complete
//   o_wr_buf_idx              buffer of the last completed frame
//   o_frame_done/_drop        frame completed / abandoned pulses
//   o_wr_err                  burst timeout pulse
module frame_write_burst_ctrl #(
    parameter int unsigned MEM_DATA_BITS = 64,
    parameter int unsigned BURST_LEN     = 128,
    parameter int unsigned FRAME_WORDS   = 518400,
    parameter int unsigned BUF_NUM       = 3,
    parameter logic [23:0] BUF_STRIDE    = 24'h080000,
    parameter int unsigned CNT_W         = 11,
    parameter int unsigned TIMEOUT       = 8000
) (
    input  logic                     i_mem_clk,
    input  logic                     i_rst,
    input  logic                     i_frame_start,
    input  logic [1:0]               i_rd_buf_idx,
    input  logic [CNT_W-1:0]         i_fifo_rd_count,
    input  logic [MEM_DATA_BITS-1:0] i_fifo_rd_data,
    output logic                     o_fifo_rd_en,
    output logic                     o_wr_burst_req,
    output logic [9:0]               o_wr_burst_len,
    output logic [23:0]              o_wr_burst_addr,
    input  logic                     i_wr_burst_data_req,
    output logic [MEM_DATA_BITS-1:0] o_wr_burst_data,
    input  logic                     i_wr_burst_finish,
    output logic [1:0]               o_wr_buf_idx,
    output logic                     o_frame_done,
    output logic                     o_frame_drop,
    output logic                     o_wr_err
);

    localparam int unsigned AW = 24;
    localparam int unsigned LW = 10;
    localparam int unsigned TW = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_REQ, S_WRITE} state_t;

    state_t          r_state, w_state_nxt;
    logic [1:0]      r_cur, w_cur_nxt;
    logic [AW-1:0]   r_offset, w_offset_nxt;
    logic [AW-1:0]   r_left, w_left_nxt;
    logic            r_pend, w_pend_nxt;
    logic            r_req, w_req_nxt;
    logic [LW-1:0]   r_len, w_len_nxt;
    logic [AW-1:0]   r_addr, w_addr_nxt;
    logic [1:0]      r_idx, w_idx_nxt;
    logic            r_done, w_done_nxt;
    logic            r_drop, w_drop_nxt;
    logic            r_err, w_err_nxt;
    logic [TW-1:0]   r_tmo, w_tmo_nxt;

    logic [1:0]      w_inc, w_sel;
    logic [LW-1:0]   w_blen;
    logic [AW-1:0]   w_addr;
    logic            w_cnt_ok;

    // Next buffer: advance by one, skipping the buffer held by the read side
    always_comb begin
        w_inc = (r_cur == 2'(BUF_NUM - 1)) ? 2'd0 : r_cur + 2'd1;
        w_sel = w_inc;
        if (w_inc == i_rd_buf_idx) begin
            w_sel = (w_inc == 2'(BUF_NUM - 1)) ? 2'd0 : w_inc + 2'd1;
        end
    end

    // Burst size and address of the next burst of the active frame
    always_comb begin
        w_blen   = (r_left >= AW'(BURST_LEN)) ? LW'(BURST_LEN) : r_left[LW-1:0];
        w_addr   = AW'(AW'(r_cur) * BUF_STRIDE + r_offset);
        w_cnt_ok = (AW'(i_fifo_rd_count) >= AW'(w_blen));
    end

    // Next-state and registered-output logic
    always_comb begin
        w_state_nxt  = r_state;
        w_cur_nxt    = r_cur;
        w_offset_nxt = r_offset;
        w_left_nxt   = r_left;
        w_pend_nxt   = r_pend;
        w_req_nxt    = r_req;
        w_len_nxt    = r_len;
        w_addr_nxt   = r_addr;
        w_idx_nxt    = r_idx;
        w_done_nxt   = 1'b0;
        w_drop_nxt   = 1'b0;
        w_err_nxt    = 1'b0;
        w_tmo_nxt    = r_tmo;

        case (r_state)
            S_IDLE: begin
                if (i_frame_start || r_pend) begin
                    w_cur_nxt    = w_sel;
                    w_offset_nxt = '0;
                    w_left_nxt   = AW'(FRAME_WORDS);
                    w_pend_nxt   = 1'b0;
                    w_state_nxt  = S_WAIT;
                end
            end
            S_WAIT: begin
                // A newer frame supersedes the partially written one
                if (i_frame_start || r_pend) begin
                    w_drop_nxt   = 1'b1;
                    w_cur_nxt    = w_sel;
                    w_offset_nxt = '0;
                    w_left_nxt   = AW'(FRAME_WORDS);
                    w_pend_nxt   = 1'b0;
                end else if (w_cnt_ok) begin
                    w_req_nxt   = 1'b1;
                    w_len_nxt   = w_blen;
                    w_addr_nxt  = w_addr;
                    w_tmo_nxt   = '0;
                    w_state_nxt = S_REQ;
                end
            end
            S_REQ, S_WRITE: begin
                // Starts during a burst wait until the burst is finished
                w_pend_nxt = r_pend | i_frame_start;
                if (r_state == S_REQ && i_wr_burst_data_req) begin
                    w_state_nxt = S_WRITE;
                end
                if (i_wr_burst_finish) begin
                    w_req_nxt    = 1'b0;
                    w_offset_nxt = r_offset + AW'(r_len);
                    w_left_nxt   = r_left - AW'(r_len);
                    if (r_left == AW'(r_len)) begin
                        w_done_nxt  = 1'b1;
                        w_idx_nxt   = r_cur;
                        w_state_nxt = S_IDLE;
                    end else begin
                        w_state_nxt = S_WAIT;
                    end
                end else if (r_tmo == TW'(TIMEOUT)) begin
                    // Abandon the frame; FIFO contents are left untouched
                    w_req_nxt   = 1'b0;
                    w_err_nxt   = 1'b1;
                    w_left_nxt  = '0;
                    w_pend_nxt  = 1'b0;
                    w_state_nxt = S_IDLE;
                end else begin
                    w_tmo_nxt = r_tmo + TW'(1);
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // State and output registers
    always_ff @(posedge i_mem_clk) begin
        if (i_rst) begin
            r_state  <= S_IDLE;
            r_cur    <= '0;
            r_offset <= '0;
            r_left   <= '0;
            r_pend   <= 1'b0;
            r_req    <= 1'b0;
            r_len    <= '0;
            r_addr   <= '0;
            r_idx    <= '0;
            r_done   <= 1'b0;
            r_drop   <= 1'b0;
            r_err    <= 1'b0;
            r_tmo    <= '0;
        end else begin
            r_state  <= w_state_nxt;
            r_cur    <= w_cur_nxt;
            r_offset <= w_offset_nxt;
            r_left   <= w_left_nxt;
            r_pend   <= w_pend_nxt;
            r_req    <= w_req_nxt;
            r_len    <= w_len_nxt;
            r_addr   <= w_addr_nxt;
            r_idx    <= w_idx_nxt;
            r_done   <= w_done_nxt;
            r_drop   <= w_drop_nxt;
            r_err    <= w_err_nxt;
            r_tmo    <= w_tmo_nxt;
        end
    end

    assign o_fifo_rd_en    = i_wr_burst_data_req;
    assign o_wr_burst_data = i_fifo_rd_data;
    assign o_wr_burst_req  = r_req;
    assign o_wr_burst_len  = r_len;
    assign o_wr_burst_addr = r_addr;
    assign o_wr_buf_idx    = r_idx;
    assign o_frame_done    = r_done;
    assign o_frame_drop    = r_drop;
    assign o_wr_err        = r_err;

endmodule

// File: tb/tb_frame_write_burst_ctrl.sv
// Testbench for frame_write_burst_ctrl: randomized arbiter/FIFO stimulus checked
// every cycle against a sequential reference model, plus directed scenarios
// with hand-computed burst lists.
module tb_frame_write_burst_ctrl;

    localparam int unsigned MDB = 64;
    localparam int unsigned BL  = 128;
    localparam int unsigned FW  = 300;
    localparam int unsigned BN  = 3;
    localparam int unsigned CW  = 11;
    localparam int unsigned TMO = 8000;
    localparam logic [23:0] STRIDE = 24'h080000;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic           fs = 1'b0;
    logic [1:0]     rd_idx = 2'd0;
    logic [CW-1:0]  cnt = '0;
    logic [MDB-1:0] fdata = '0;
    logic           dreq = 1'b0;
    logic           fin = 1'b0;

    logic           o_fifo_rd_en;
    logic           o_wr_burst_req;
    logic [9:0]     o_wr_burst_len;
    logic [23:0]    o_wr_burst_addr;
    logic [MDB-1:0] o_wr_burst_data;
    logic [1:0]     o_wr_buf_idx;
    logic           o_frame_done;
    logic           o_frame_drop;
    logic           o_wr_err;

    frame_write_burst_ctrl #(
        .MEM_DATA_BITS(MDB), .BURST_LEN(BL), .FRAME_WORDS(FW), .BUF_NUM(BN),
        .BUF_STRIDE(STRIDE), .CNT_W(CW), .TIMEOUT(TMO)
    ) dut (
        .i_mem_clk(clk), .i_rst(rst), .i_frame_start(fs), .i_rd_buf_idx(rd_idx),
        .i_fifo_rd_count(cnt), .i_fifo_rd_data(fdata), .o_fifo_rd_en(o_fifo_rd_en),
        .o_wr_burst_req(o_wr_burst_req), .o_wr_burst_len(o_wr_burst_len),
        .o_wr_burst_addr(o_wr_burst_addr), .i_wr_burst_data_req(dreq),
        .o_wr_burst_data(o_wr_burst_data), .i_wr_burst_finish(fin),
        .o_wr_buf_idx(o_wr_buf_idx), .o_frame_done(o_frame_done),
        .o_frame_drop(o_frame_drop), .o_wr_err(o_wr_err)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    bit cmp_en = 1'b0;
    bit bfm_hold = 1'b0;

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0h want %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    logic        s_rst, s_fs, s_fin;
    logic [1:0]  s_rd;
    int unsigned s_cnt;
    int unsigned m_cur, m_off, m_left;
    bit          m_pend;
    logic        exp_req, exp_done, exp_drop, exp_err;
    logic [9:0]  exp_len;
    logic [23:0] exp_addr;
    logic [1:0]  exp_idx;

    task automatic m_edge();
        @(posedge clk);
        s_rst = rst; s_fs = fs; s_fin = fin; s_rd = rd_idx; s_cnt = cnt;
        exp_done = 1'b0; exp_drop = 1'b0; exp_err = 1'b0;
    endtask

    task automatic model_reset();
        m_cur = 0; m_off = 0; m_left = 0; m_pend = 1'b0;
        exp_req = 1'b0; exp_len = '0; exp_addr = '0; exp_idx = '0;
        exp_done = 1'b0; exp_drop = 1'b0; exp_err = 1'b0;
    endtask

    task automatic select_buf();
        int unsigned n;
        n = (m_cur + 1) % BN;
        if (n == s_rd) n = (n + 1) % BN;
        m_cur = n; m_off = 0; m_left = FW;
    endtask

    // Writes one frame as a sequence of bursts; returns when the frame ends
    task automatic run_frame();
        int unsigned blen, tcnt;
        forever begin
            m_edge();
            if (s_rst) begin model_reset(); return; end
            if (s_fs || m_pend) begin
                exp_drop = 1'b1; select_buf(); m_pend = 1'b0;
                continue;
            end
            blen = (m_left < BL) ? m_left : BL;
            if (s_cnt < blen) continue;
            exp_req = 1'b1; exp_len = 10'(blen);
            exp_addr = 24'(m_cur * STRIDE + m_off);
            tcnt = 0;
            forever begin
                m_edge();
                if (s_rst) begin model_reset(); return; end
                if (s_fin) break;
                if (tcnt == TMO) begin
                    exp_req = 1'b0; exp_err = 1'b1; m_left = 0; m_pend = 1'b0;
                    return;
                end
                if (s_fs) m_pend = 1'b1;
                tcnt++;
            end
            if (s_fs) m_pend = 1'b1;
            exp_req = 1'b0; m_off += blen; m_left -= blen;
            if (m_left == 0) begin
                exp_done = 1'b1; exp_idx = 2'(m_cur);
                return;
            end
        end
    endtask

    initial begin
        model_reset();
        forever begin
            m_edge();
            if (s_rst) begin model_reset(); continue; end
            if (s_fs || m_pend) begin
                select_buf(); m_pend = 1'b0;
                run_frame();
            end
        end
    end

    // ---------------- compare process ----------------
    initial begin
        forever begin
            @(negedge clk);
            if (cmp_en) begin
                check("req",   64'(o_wr_burst_req),  64'(exp_req));
                check("len",   64'(o_wr_burst_len),  64'(exp_len));
                check("addr",  64'(o_wr_burst_addr), 64'(exp_addr));
                check("bufidx",64'(o_wr_buf_idx),    64'(exp_idx));
                check("done",  64'(o_frame_done),    64'(exp_done));
                check("drop",  64'(o_frame_drop),    64'(exp_drop));
                check("err",   64'(o_wr_err),        64'(exp_err));
                check("rd_en", 64'(o_fifo_rd_en),    64'(dreq));
                check("wdata", o_wr_burst_data,      fdata);
            end
        end
    end

    // ---------------- event monitor ----------------
    logic [33:0] bq[$];
    int n_done = 0, n_drop = 0, n_err = 0;
    logic prev_req = 1'b0;
    initial begin
        forever begin
            @(negedge clk);
            if (o_wr_burst_req === 1'b1 && prev_req !== 1'b1)
                bq.push_back({o_wr_burst_len, o_wr_burst_addr});
            prev_req = o_wr_burst_req;
            if (o_frame_done === 1'b1) n_done++;
            if (o_frame_drop === 1'b1) n_drop++;
            if (o_wr_err === 1'b1)     n_err++;
        end
    end

    // ---------------- FIFO data and arbiter BFM ----------------
    initial begin
        forever begin
            @(posedge clk); #2;
            fdata = {$urandom, $urandom};
        end
    end

    initial begin : bfm
        int unsigned left_w;
        forever begin
            @(posedge clk); #2;
            dreq = 1'b0; fin = 1'b0;
            if (o_wr_burst_req !== 1'b1) continue;
            left_w = o_wr_burst_len;
            while (1) begin
                if (o_wr_burst_req !== 1'b1) begin dreq = 1'b0; fin = 1'b0; break; end
                if (left_w > 0) begin
                    if ($urandom_range(0, 3) != 0) begin dreq = 1'b1; left_w--; end
                    else dreq = 1'b0;
                end else begin
                    dreq = 1'b0;
                    if (!bfm_hold && $urandom_range(0, 1) == 0) fin = 1'b1;
                end
                @(posedge clk); #2;
                dreq = 1'b0;
                if (fin) begin fin = 1'b0; break; end
            end
        end
    end

    // ---------------- directed + random stimulus ----------------
    task automatic cyc();
        @(posedge clk); #2;
    endtask

    task automatic smp();
        @(negedge clk); #1;
    endtask

    function automatic int evt(input int which);
        case (which)
            0: evt = n_done;
            1: evt = n_drop;
            default: evt = bq.size();
        endcase
    endfunction

    task automatic wait_evt(input int which, input int target, input int lim, input string nm);
        int k;
        k = 0;
        while (evt(which) < target && k < lim) begin smp(); k++; end
        if (evt(which) < target) check(nm, 64'(evt(which)), 64'(target));
    endtask

    task automatic pulse_start();
        fs = 1'b1; cyc(); fs = 1'b0;
    endtask

    initial begin
        int b, d0, hi, k, e0, r0, p0;
        repeat (3) cyc();
        cmp_en = 1'b1;
        cyc();
        rst = 1'b0;
        smp();
        check("rst_req",  64'(o_wr_burst_req),  64'd0);
        check("rst_len",  64'(o_wr_burst_len),  64'd0);
        check("rst_addr", 64'(o_wr_burst_addr), 64'd0);
        check("rst_idx",  64'(o_wr_buf_idx),    64'd0);

        // Three bursts into buffer 1
        cyc(); rd_idx = 2'd0; cnt = 11'd512;
        b = bq.size(); d0 = n_done;
        pulse_start();
        wait_evt(0, d0 + 1, 3000, "t1_done_timeout");
        check("t1_nbursts", 64'(bq.size() - b), 64'd3);
        if (bq.size() >= b + 3) begin
            check("t1_b0", 64'(bq[b]),   64'({10'd128, 24'h080000}));
            check("t1_b1", 64'(bq[b+1]), 64'({10'd128, 24'h080080}));
            check("t1_b2", 64'(bq[b+2]), 64'({10'd44,  24'h080100}));
        end
        check("t1_idx", 64'(o_wr_buf_idx), 64'd1);

        // Buffer 2 is owned by the reader, so buffer 0 is chosen; FIFO thresholds
        cyc(); rd_idx = 2'd2; cnt = 11'd100;
        b = bq.size(); d0 = n_done;
        pulse_start();
        repeat (20) cyc();
        smp();
        check("t3_no_req_100", 64'(bq.size() - b), 64'd0);
        cyc(); cnt = 11'd128;
        repeat (2) cyc();
        smp();
        check("t3_req_128", 64'(bq.size() - b), 64'd1);
        if (bq.size() >= b + 1) check("t2_addr", 64'(bq[b]), 64'({10'd128, 24'h000000}));
        wait_evt(2, b + 2, 2000, "t3_b1_timeout");
        cyc(); cnt = 11'd43;
        repeat (600) cyc();
        smp();
        check("t3_no_req_43", 64'(bq.size() - b), 64'd2);
        cyc(); cnt = 11'd44;
        wait_evt(0, d0 + 1, 2000, "t3_done_timeout");
        if (bq.size() >= b + 3) check("t3_last", 64'(bq[b+2]), 64'({10'd44, 24'h000100}));
        check("t3_idx", 64'(o_wr_buf_idx), 64'd0);

        // New start during burst 2 of a frame: burst finishes, frame dropped
        cyc(); rd_idx = 2'd0; cnt = 11'd512;
        b = bq.size(); d0 = n_done; p0 = n_drop;
        pulse_start();
        wait_evt(2, b + 2, 2000, "t4_b1_timeout");
        k = 0;
        smp();
        while (dreq !== 1'b1 && k < 100) begin smp(); k++; end
        check("t4_in_write", 64'(dreq), 64'd1);
        cyc(); fs = 1'b1; cyc(); fs = 1'b0;
        wait_evt(1, p0 + 1, 2000, "t4_drop_timeout");
        check("t4_nb_at_drop", 64'(bq.size() - b), 64'd2);
        wait_evt(2, b + 3, 2000, "t4_b2_timeout");
        if (bq.size() >= b + 3) begin
            check("t4_b1", 64'(bq[b+1]), 64'({10'd128, 24'h080080}));
            check("t4_new", 64'(bq[b+2]), 64'({10'd128, 24'h100000}));
        end
        wait_evt(0, d0 + 1, 3000, "t4_done_timeout");
        check("t4_idx", 64'(o_wr_buf_idx), 64'd2);

        // Arbiter never finishes: timeout after TMO+1 request cycles
        cyc(); bfm_hold = 1'b1; rd_idx = 2'd3;
        e0 = n_err;
        pulse_start();
        k = 0;
        smp();
        while (o_wr_burst_req !== 1'b1 && k < 100) begin smp(); k++; end
        hi = 0;
        while (o_wr_burst_req === 1'b1 && hi < TMO + 100) begin hi++; smp(); end
        check("t5_req_cycles", 64'(hi), 64'(TMO + 1));
        check("t5_err_pulses", 64'(n_err - e0), 64'd1);
        b = bq.size();
        repeat (30) cyc();
        smp();
        check("t5_idle", 64'(bq.size() - b), 64'd0);
        cyc(); bfm_hold = 1'b0;

        // Reset in the middle of a burst
        rd_idx = 2'd0;
        pulse_start();
        k = 0;
        smp();
        while (dreq !== 1'b1 && k < 200) begin smp(); k++; end
        check("t6_in_write", 64'(dreq), 64'd1);
        d0 = n_done; p0 = n_drop; e0 = n_err;
        cyc(); rst = 1'b1; cyc(); rst = 1'b0;
        smp();
        check("t6_req",  64'(o_wr_burst_req),  64'd0);
        check("t6_len",  64'(o_wr_burst_len),  64'd0);
        check("t6_addr", 64'(o_wr_burst_addr), 64'd0);
        check("t6_idx",  64'(o_wr_buf_idx),    64'd0);
        repeat (10) cyc();
        smp();
        check("t6_pulses", 64'((n_done - d0) + (n_drop - p0) + (n_err - e0)), 64'd0);

        // Randomized traffic checked by the model
        r0 = n_done;
        for (int i = 0; i < 20000; i++) begin
            cyc();
            cnt = ($urandom_range(0, 9) < 7) ? 11'd512 : 11'($urandom_range(0, 200));
            fs  = ($urandom_range(0, 249) == 0);
            if (fs) rd_idx = 2'($urandom_range(0, 3));
            rst = ($urandom_range(0, 4999) == 0);
        end
        cyc(); fs = 1'b0; rst = 1'b0;
        repeat (5) cyc();
        smp();
        check("rand_progress", 64'(n_done > r0), 64'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
